// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry valid/ready holding register.
// Frame: start, 8 data bits LSB first, even parity, 1 or 2 stop bits.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rx_i              serial line (asynchronous, idles high)
//   cfg_en_i          receiver enable
//   cfg_stop_bits_i   0 = one stop bit, 1 = two stop bits
//   rx_data_o         received byte in the holding register
//   rx_valid_o        holding register full
//   rx_ready_i        consumer accepts the byte
//   parity_err_o      parity mismatch for the held byte
//   frame_err_o       stop bit sampled low for the held byte
//   overrun_err_o     one-cycle pulse when a completed byte is dropped
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       cfg_en_i,
  input  logic       cfg_stop_bits_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] BIT_TGT  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic [7:0]       shift_q, shift_nxt;
  logic             par_q, par_nxt;
  logic             perr_q, perr_nxt;
  logic             rx_meta, rx_s, rx_d;
  logic [CNT_W-1:0] tgt_c;
  logic             tick_c, deliver_c, ferr_c;

  // Two-flop synchronizer plus a delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      shift_q <= shift_nxt;
      par_q   <= par_nxt;
      perr_q  <= perr_nxt;
    end
  end

  // Next-state, baud counter and delivery strobe.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    perr_nxt  = perr_q;
    deliver_c = 1'b0;
    ferr_c    = 1'b0;
    tgt_c     = (state_q == S_START) ? HALF_TGT : BIT_TGT;
    tick_c    = (state_q != S_IDLE) && (cnt_q == tgt_c);

    case (state_q)
      S_IDLE: begin
        if (rx_d && !rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (tick_c) begin
          if (!rx_s) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
            par_nxt   = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_nxt = {rx_s, shift_q[7:1]};
          par_nxt   = par_q ^ rx_s;
          if (idx_q == 3'd7) state_nxt = S_PARITY;
          else               idx_nxt   = 3'(idx_q + 3'd1);
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          perr_nxt  = par_q ^ rx_s;
          state_nxt = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick_c) begin
          if (!rx_s) begin
            deliver_c = 1'b1;
            ferr_c    = 1'b1;
            state_nxt = S_IDLE;
          end else if (cfg_stop_bits_i) begin
            state_nxt = S_STOP2;
          end else begin
            deliver_c = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick_c) begin
          deliver_c = 1'b1;
          ferr_c    = !rx_s;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Disabling drops any partial frame, including one finishing this cycle.
    if (!cfg_en_i) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      deliver_c = 1'b0;
    end

    // Counter restarts on every state entry and after each tick; idle holds it at zero.
    if ((state_nxt != state_q) || tick_c || (state_q == S_IDLE)) cnt_nxt = '0;
    else                                                          cnt_nxt = cnt_q + CNT_W'(1);
  end

  // One-entry holding register with overrun detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      overrun_err_o <= 1'b0;
      if (deliver_c) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= shift_q;
          parity_err_o <= perr_q;
          frame_err_o  <= ferr_c;
          rx_valid_o   <= 1'b1;
        end else begin
          overrun_err_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against an arithmetic frame model.
module tb_uart_rx;
  localparam int unsigned CLK_FREQ  = 1600000;
  localparam int unsigned BAUD_RATE = 100000;
  localparam int unsigned BITC      = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic       cfg_en_i;
  logic       cfg_stop_bits_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;

  int n_chk = 0;
  int n_pass = 0;
  int ovr_cnt = 0;
  logic [9:0] cap_q[$];
  logic [9:0] exp_q[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .cfg_en_i(cfg_en_i),
    .cfg_stop_bits_i(cfg_stop_bits_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .overrun_err_o(overrun_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted bytes ({ferr, perr, data}) and overrun pulses on the falling edge.
  always @(negedge clk) begin
    if (rst && rx_valid_o && rx_ready_i) cap_q.push_back({frame_err_o, parity_err_o, rx_data_o});
    if (overrun_err_o) ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BITC) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input logic two);
    cfg_stop_bits_i = two;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rx_i = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!rx_valid_o && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, 32'(rx_valid_o), 32'd1);
  endtask

  task automatic check_held(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    wait_valid(tag);
    chk({tag, "_data"}, 32'(rx_data_o), 32'(d));
    chk({tag, "_perr"}, 32'(parity_err_o), 32'(pe));
    chk({tag, "_ferr"}, 32'(frame_err_o), 32'(fe));
  endtask

  task automatic drain(input string tag);
    rx_ready_i = 1'b1;
    step();
    chk({tag, "_clear"}, 32'(rx_valid_o), 32'd0);
    rx_ready_i = 1'b0;
    repeat (10) step();
  endtask

  task automatic compare_queues(input string tag);
    logic [31:0] obs;
    chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD;
      chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
    end
  endtask

  initial begin
    int base;
    logic [7:0] d;
    logic p, s1, s2, two, corrupt, last;
    int gap;

    rx_i = 1'b1;
    cfg_en_i = 1'b1;
    cfg_stop_bits_i = 1'b0;
    rx_ready_i = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    chk("rst_perr", 32'(parity_err_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    chk("rst_ovr", 32'(overrun_err_o), 32'd0);
    rst = 1'b1;
    repeat (5) step();

    // Clean byte, one stop bit.
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1, 1'b0);
    check_held("a5", 8'hA5, 1'b0, 1'b0);
    drain("a5");

    // Wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    check_held("par", 8'h01, 1'b1, 1'b0);
    drain("par");

    // Two stop bits: second one low, then both high.
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0, 1'b1);
    check_held("stop2_bad", 8'h3C, 1'b0, 1'b1);
    drain("stop2_bad");
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b1, 1'b1);
    check_held("stop2_ok", 8'h3C, 1'b0, 1'b0);
    drain("stop2_ok");
    cfg_stop_bits_i = 1'b0;

    // Short low glitch must not deliver anything.
    base = ovr_cnt;
    rx_i = 1'b0;
    repeat (4) step();
    rx_i = 1'b1;
    repeat (40) step();
    chk("glitch_valid", 32'(rx_valid_o), 32'd0);
    chk("glitch_ovr", 32'(ovr_cnt - base), 32'd0);
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b1, 1'b0);
    check_held("post_glitch", 8'h5A, 1'b0, 1'b0);
    drain("post_glitch");

    // Back-to-back with no consumer: second byte dropped, one overrun pulse.
    base = ovr_cnt;
    send_frame(8'h11, ^8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b1, 1'b0);
    repeat (10) step();
    chk("ovr_valid", 32'(rx_valid_o), 32'd1);
    chk("ovr_data", 32'(rx_data_o), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    drain("ovr");

    // Back-to-back with consumer always ready: both bytes arrive.
    base = ovr_cnt;
    cap_q.delete();
    exp_q.delete();
    rx_ready_i = 1'b1;
    send_frame(8'h11, ^8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({2'b00, 8'h11});
    exp_q.push_back({2'b00, 8'h22});
    repeat (20) step();
    compare_queues("b2b");
    chk("b2b_ovr", 32'(ovr_cnt - base), 32'd0);
    rx_ready_i = 1'b0;

    // Reset in the middle of a frame while a byte is held.
    send_frame(8'hC3, ^8'hC3, 1'b1, 1'b1, 1'b0);
    check_held("pre_rst", 8'hC3, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(rx_valid_o), 32'd0);
    chk("midrst_data", 32'(rx_data_o), 32'd0);
    chk("midrst_perr", 32'(parity_err_o), 32'd0);
    chk("midrst_ferr", 32'(frame_err_o), 32'd0);
    chk("midrst_ovr", 32'(overrun_err_o), 32'd0);
    repeat (3) step();
    rx_i = 1'b1;
    rst = 1'b1;
    repeat (20) step();
    send_frame(8'h80, ^8'h80, 1'b1, 1'b1, 1'b0);
    check_held("post_rst", 8'h80, 1'b0, 1'b0);
    drain("post_rst");

    // Randomized frames: parity and framing errors predicted from the frame contents.
    base = ovr_cnt;
    cap_q.delete();
    exp_q.delete();
    rx_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      corrupt = ($urandom_range(0, 3) == 0);
      p = (^d) ^ corrupt;
      two = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      exp_q.push_back({(!s1 || (two && !s2)), corrupt, d});
      send_frame(d, p, s1, s2, two);
      last = two ? s2 : s1;
      gap = $urandom_range(0, 30);
      if (!last && gap < 20) gap = 20;
      repeat (gap) step();
    end
    repeat (40) step();
    compare_queues("rand");
    chk("rand_ovr", 32'(ovr_cnt - base), 32'd0);
    rx_ready_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, counterpart of the peripheral transmitter on the same serial link.
- Frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), then 1 or 2 stop bits.
- Oversamples the line with a per-bit counter and presents each received byte through a one-entry valid/ready holding register, with per-byte parity and framing status.
- Sits in the UART peripheral beside the transmitter; the register interface consumes its output.

Parameters:
- CLK_FREQ, 50000000, peripheral clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- Derived constants (localparams): BIT_CYCLES = CLK_FREQ/BAUD_RATE; HALF_CYCLES = BIT_CYCLES/2. The counter width is clog2(BIT_CYCLES)+1.

Ports:
- clk  input  1  peripheral clock.
- rst  input  1  asynchronous, active-low reset.
- rx_i  input  1  serial line, asynchronous to clk; idles high.
- cfg_en_i  input  1  receiver enable.
- cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
- rx_data_o  output  8  received byte in the holding register.
- rx_valid_o  output  1  holding register full.
- rx_ready_i  input  1  consumer accepts the byte.
- parity_err_o  output  1  parity mismatch for the byte in rx_data_o; valid while rx_valid_o=1.
- frame_err_o  output  1  stop bit sampled low for the byte in rx_data_o; valid while rx_valid_o=1.
- overrun_err_o  output  1  one-cycle pulse: a completed byte was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0, shift register=0.
  - Both synchronizer flops = 1.
  - rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, overrun_err_o=0.
- Input path: rx_i passes through 2 flops to give rx_s. Edge detection uses rx_s and a third flop rx_d. A start edge is rx_d=1 and rx_s=0.
- Baud counter: cleared on every state entry. It increments each cycle and a "tick" fires when it reaches the state's target, then it clears.
- States:
  - IDLE: counter held at 0. On a start edge, go to START.
  - START: target HALF_CYCLES-1. On tick, if rx_s=0 go to DATA (bit index 0, parity accumulator 0). Otherwise this is a glitch: go to IDLE.
  - DATA: target BIT_CYCLES-1. On tick:
    - shift rx_s into the MSB of the shift register (right shift), and XOR it into the parity accumulator.
    - after index 7, go to PARITY; otherwise increment the index.
  - PARITY: target BIT_CYCLES-1. On tick, parity_error = accumulator XOR rx_s. Go to STOP1.
  - STOP1: target BIT_CYCLES-1. On tick:
    - if rx_s=0: deliver with frame_err=1 and go to IDLE.
    - else if cfg_stop_bits_i=1: go to STOP2.
    - else: deliver with frame_err=0 and go to IDLE.
  - STOP2: target BIT_CYCLES-1. On tick, deliver with frame_err=!rx_s and go to IDLE.
- Delivery happens at the mid-bit sample of the final stop bit. The receiver is back in IDLE half a bit early, so back-to-back frames are not missed.
- Holding register:
  - Delivery loads the byte and both error flags, and sets rx_valid_o one cycle after the tick.
  - rx_valid_o clears on any cycle where rx_valid_o=1 and rx_ready_i=1.
  - Delivery in the same cycle as a handshake: the new byte is loaded and rx_valid_o stays 1. No overrun.
  - Delivery while rx_valid_o=1 with no handshake: the new byte is discarded, the old byte and flags are retained, and overrun_err_o pulses 1 cycle.
- Frame error recovery: after a frame error, IDLE will not re-trigger until rx_s has been seen high (the edge rule enforces this). A held-low line (break) yields exactly one frame-error byte.
- cfg_en_i=0:
  - state is forced to IDLE and counters cleared on the next clock; any partial frame is dropped.
  - the holding register and handshake keep operating.
  - the synchronizer keeps running.
- cfg_stop_bits_i is sampled at the STOP1 tick only.
- rx_valid_o does not depend combinationally on rx_ready_i. All outputs are registered.

Test Plan (CLK_FREQ=1600000, BAUD_RATE=100000, so BIT_CYCLES=16):
- Send 0xA5 with parity 0 and 1 stop bit, rx_ready_i=0 → rx_valid_o rises, rx_data_o=0xA5, parity_err_o=0, frame_err_o=0. It then clears the cycle after rx_ready_i=1.
- Send 0x01 with the parity bit driven 0 → rx_data_o=0x01, parity_err_o=1, frame_err_o=0.
- cfg_stop_bits_i=1: send 0x3C with STOP1=1 and STOP2=0 → frame_err_o=1. Then send 0x3C with both stop bits 1 → frame_err_o=0.
- 4-cycle low glitch on rx_i in IDLE → no delivery, state returns to IDLE. A following valid 0x5A frame is received correctly.
- Two back-to-back frames 0x11 then 0x22, rx_ready_i held 0 → rx_data_o stays 0x11 and overrun_err_o pulses once. Repeat with rx_ready_i=1 → 0x11 then 0x22, no overrun.
- Assert rst low mid-DATA of 0xFF → all outputs 0 immediately. After release, a clean 0x80 frame is received with no errors.
